// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: HDMI raster timing generator and pixel sink.
// Drives scan coordinates hx/hy to the upscaler, takes back rgb_h
// PIXEL_LATENCY clocks later, and delays de/hsync/vsync to match it.
// Every coordinate shows up on rgb/de/hsync/vsync PIXEL_LATENCY+1 clocks
// after it is presented on hx/hy.
//
// Ports:
//   clk_h      HDMI pixel clock
//   rst_h_n    asynchronous active-low reset
//   en         start/run request; stopping happens only at the frame boundary
//   hx, hy     registered scan coordinates to the upscaler
//   rgb_h      upscaler pixel, valid PIXEL_LATENCY clocks after hx/hy
//   rgb        aligned pixel, black outside the active area
//   hsync      aligned horizontal sync
//   vsync      aligned vertical sync
//   de         aligned data enable
//   new_frame  high for the whole line hy == NEWFRAME_LINE (not delayed)
//   running    high while in RUN
module hdmi_timing_gen #(
   parameter int unsigned OSCREEN_WIDTH  = 720,
   parameter int unsigned OSCREEN_HEIGHT = 480,
   parameter int unsigned OFRAME_WIDTH   = 858,
   parameter int unsigned OFRAME_HEIGHT  = 525,
   parameter int unsigned HSYNC_START    = 736,
   parameter int unsigned HSYNC_END      = 798,
   parameter int unsigned VSYNC_START    = 489,
   parameter int unsigned VSYNC_END      = 495,
   parameter logic        SYNC_ACTIVE    = 1'b0,
   parameter int unsigned PIXEL_LATENCY  = 2,
   parameter int unsigned NEWFRAME_LINE  = OFRAME_HEIGHT - 3
) (
   input  logic        clk_h,
   input  logic        rst_h_n,
   input  logic        en,
   output logic [9:0]  hx,
   output logic [9:0]  hy,
   input  logic [23:0] rgb_h,
   output logic [23:0] rgb,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        new_frame,
   output logic        running
);

   // One spare bit so a bound of 1024 still compares correctly.
   localparam int unsigned CW = 11;
   localparam int unsigned FW = 3;
   localparam logic [CW-1:0] HX_LAST  = CW'(OFRAME_WIDTH - 1);
   localparam logic [CW-1:0] HY_LAST  = CW'(OFRAME_HEIGHT - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(OSCREEN_WIDTH);
   localparam logic [CW-1:0] V_ACT    = CW'(OSCREEN_HEIGHT);
   localparam logic [CW-1:0] HS_START = CW'(HSYNC_START);
   localparam logic [CW-1:0] HS_END   = CW'(HSYNC_END);
   localparam logic [CW-1:0] VS_START = CW'(VSYNC_START);
   localparam logic [CW-1:0] VS_END   = CW'(VSYNC_END);
   localparam logic [CW-1:0] NF_LINE  = CW'(NEWFRAME_LINE);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(PIXEL_LATENCY - 1);
   localparam logic          SYNC_OFF = ~SYNC_ACTIVE;

   typedef enum logic [1:0] {IDLE, FLUSH, RUN} state_t;

   state_t          state;
   logic [FW-1:0]   flush_cnt;
   logic [CW-1:0]   hx_w, hy_w;
   logic            line_end_c, frame_end_c;
   logic [9:0]      hx_next_c, hy_next_c;
   logic            de_raw_c, hs_raw_c, vs_raw_c;

   logic [PIXEL_LATENCY-1:0] de_pipe, hs_pipe, vs_pipe;

   assign hx_w = {1'b0, hx};
   assign hy_w = {1'b0, hy};

   // Counter wrap logic.
   assign line_end_c  = (hx_w == HX_LAST);
   assign frame_end_c = line_end_c && (hy_w == HY_LAST);
   assign hx_next_c   = line_end_c ? 10'd0 : hx + 10'd1;
   assign hy_next_c   = line_end_c ? (frame_end_c ? 10'd0 : hy + 10'd1) : hy;

   // Raw timing from the registered coordinates; idle feeds blanking so the
   // parked 0,0 coordinate never reaches the outputs.
   always_comb begin
      de_raw_c = 1'b0;
      hs_raw_c = SYNC_OFF;
      vs_raw_c = SYNC_OFF;
      if (state != IDLE) begin
         de_raw_c = (hx_w < H_ACT) && (hy_w < V_ACT);
         hs_raw_c = (hx_w >= HS_START && hx_w < HS_END) ? SYNC_ACTIVE : SYNC_OFF;
         vs_raw_c = (hy_w >= VS_START && hy_w < VS_END) ? SYNC_ACTIVE : SYNC_OFF;
      end
   end

   assign new_frame = (hy_w == NF_LINE);

   // Control FSM and scan counters.
   always_ff @(posedge clk_h or negedge rst_h_n) begin
      if (!rst_h_n) begin
         state     <= IDLE;
         flush_cnt <= '0;
         running   <= 1'b0;
         hx        <= '0;
         hy        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state     <= FLUSH;
                  flush_cnt <= '0;
               end
            end
            FLUSH: begin
               flush_cnt <= flush_cnt + FW'(1);
               if (flush_cnt == FLUSH_LAST) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               // Stop only at the frame boundary so the sink always sees whole frames.
               if (frame_end_c && !en) begin
                  state   <= IDLE;
                  running <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase

         if (state == IDLE) begin
            hx <= '0;
            hy <= '0;
         end else begin
            hx <= hx_next_c;
            hy <= hy_next_c;
         end
      end
   end

   // Delay line for de/hsync/vsync, PIXEL_LATENCY stages deep.
   always_ff @(posedge clk_h or negedge rst_h_n) begin
      if (!rst_h_n) begin
         de_pipe <= '0;
         hs_pipe <= {PIXEL_LATENCY{SYNC_OFF}};
         vs_pipe <= {PIXEL_LATENCY{SYNC_OFF}};
      end else begin
         de_pipe[0] <= de_raw_c;
         hs_pipe[0] <= hs_raw_c;
         vs_pipe[0] <= vs_raw_c;
         for (int i = 1; i < PIXEL_LATENCY; i++) begin
            de_pipe[i] <= de_pipe[i-1];
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
         end
      end
   end

   // Output stage: rgb is captured in the same clock as the delayed timing.
   always_ff @(posedge clk_h or negedge rst_h_n) begin
      if (!rst_h_n) begin
         de    <= 1'b0;
         hsync <= SYNC_OFF;
         vsync <= SYNC_OFF;
         rgb   <= '0;
      end else if (state == FLUSH) begin
         de    <= 1'b0;
         hsync <= SYNC_OFF;
         vsync <= SYNC_OFF;
         rgb   <= '0;
      end else begin
         de    <= de_pipe[PIXEL_LATENCY-1];
         hsync <= hs_pipe[PIXEL_LATENCY-1];
         vsync <= vs_pipe[PIXEL_LATENCY-1];
         rgb   <= de_pipe[PIXEL_LATENCY-1] ? rgb_h : 24'h0;
      end
   end

endmodule
